// File: rtl/jkff_counter_pkg.sv
// Shared constants for the JK flip-flop based up/down counter.
package jkff_counter_pkg;

    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : jkff_counter_pkg

// File: rtl/jk_ff.sv
// Single JK flip-flop with asynchronous active-high reset to 0.
module jk_ff (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b00:   q_q <= q_q;
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                default: q_q <= ~q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule : jk_ff

// File: rtl/jkff_updown_counter.sv
// Modulo-N up/down counter with load, wrap/saturate modes and wrap pulse,
// built from one JK flip-flop per count bit.
module jkff_updown_counter
    import jkff_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // One extra bit so MODULUS = 2**WIDTH is representable.
    localparam int unsigned XW = WIDTH + 1;
    localparam logic [XW-1:0] MOD_X = XW'(MODULUS);
    localparam logic [XW-1:0] TOP_X = XW'(MODULUS - 1);

    logic [XW-1:0]    cnt_x;
    logic [XW-1:0]    ld_x;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             at_top;
    logic             at_zero;
    logic             wrap_d;
    logic             wrap_q;

    assign cnt_x   = {1'b0, q};
    assign ld_x    = {1'b0, load_val};
    assign at_top  = (cnt_x == TOP_X);
    assign at_zero = (q == '0);

    assign tc = en & ((up_dn & at_top) | (~up_dn & at_zero));

    // Next count, wrap event and per-bit J/K drive.
    always_comb begin
        q_d    = q;
        wrap_d = 1'b0;
        j      = '0;
        k      = '0;
        if (load) begin
            q_d = (ld_x >= MOD_X) ? TOP_X[WIDTH-1:0] : load_val;
        end else if (en) begin
            if (up_dn == CNT_UP) begin
                if (!at_top) begin
                    q_d = WIDTH'(cnt_x + XW'(1));
                end else if (sat == MODE_WRAP) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_d = WIDTH'(cnt_x - XW'(1));
                end else if (sat == MODE_WRAP) begin
                    q_d    = TOP_X[WIDTH-1:0];
                    wrap_d = 1'b1;
                end
            end
        end
        if (load) begin
            j = q_d;
            k = ~q_d;
        end else begin
            j = q ^ q_d;
            k = q ^ q_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff u_bit (
            .clk  (clk),
            .reset(reset),
            .j    (j[i]),
            .k    (k[i]),
            .q    (q[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule : jkff_updown_counter
